// File: rtl/lcd_sync_gen_if.sv
// Bundle of panel-side timing outputs produced by lcd_sync_gen.
//   master : driven by the timing generator
//   slave  : consumed by pixel-source / framebuffer logic
// Signals:
//   GREST       panel global reset, active-low
//   HD / VD     horizontal / vertical sync
//   DEN         data enable, high in the active area
//   Columna     active-area column (0 outside the active area)
//   Fila        active-area row (0 outside the active area)
//   PIX_TICK    one-clock strobe at the start of each pixel period
//   LINE_START  one-clock strobe at the start of each line
//   FRAME_START one-clock strobe at the start of each frame
//   FRAME_CNT   completed-frame count, wraps modulo 2^16
interface lcd_sync_gen_if #(
   parameter int unsigned COL_W = 11,
   parameter int unsigned ROW_W = 10
) ();
   logic             GREST;
   logic             HD;
   logic             VD;
   logic             DEN;
   logic [COL_W-1:0] Columna;
   logic [ROW_W-1:0] Fila;
   logic             PIX_TICK;
   logic             LINE_START;
   logic             FRAME_START;
   logic [15:0]      FRAME_CNT;

   modport master (
      output GREST, HD, VD, DEN, Columna, Fila, PIX_TICK, LINE_START, FRAME_START, FRAME_CNT
   );

   modport slave (
      input GREST, HD, VD, DEN, Columna, Fila, PIX_TICK, LINE_START, FRAME_START, FRAME_CNT
   );
endinterface

// File: rtl/lcd_sync_gen.sv
// Parametrised parallel-RGB LCD timing generator.
// Ports:
//   CLK  system clock, rising edge
//   RST  synchronous reset, active-high
//   lcd  lcd_sync_gen_if master: GREST, HD, VD, DEN, Columna, Fila,
//        PIX_TICK, LINE_START, FRAME_START, FRAME_CNT (all registered)
// A pixel-clock divider d steps the horizontal counter h once every CLK_DIV
// clocks; h wraps into the vertical counter v. Outputs are decoded from the
// current (d, h, v) and registered, so they trail the counters by one clock.
module lcd_sync_gen #(
   parameter int unsigned H_ACTIVE   = 800,
   parameter int unsigned H_FP       = 210,
   parameter int unsigned H_SYNC     = 1,
   parameter int unsigned H_BP       = 45,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 22,
   parameter int unsigned V_SYNC     = 1,
   parameter int unsigned V_BP       = 22,
   parameter int unsigned HS_ACT_LOW = 1,
   parameter int unsigned VS_ACT_LOW = 1,
   parameter int unsigned CLK_DIV    = 1,
   parameter int unsigned COL_W      = 11,
   parameter int unsigned ROW_W      = 10
) (
   input  logic           CLK,
   input  logic           RST,
   lcd_sync_gen_if.master lcd
);

   localparam int unsigned HTotal = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned VTotal = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (longint'(HTotal) - 1 >= (longint'(1) << COL_W)) begin : g_bad_col_w
      $error("lcd_sync_gen: H_TOTAL-1 does not fit in COL_W bits");
   end
   if (longint'(VTotal) - 1 >= (longint'(1) << ROW_W)) begin : g_bad_row_w
      $error("lcd_sync_gen: V_TOTAL-1 does not fit in ROW_W bits");
   end
   if (CLK_DIV < 1) begin : g_bad_div
      $error("lcd_sync_gen: CLK_DIV must be at least 1");
   end

   localparam logic [DivW-1:0]  DLast    = DivW'(CLK_DIV - 1);
   localparam logic [COL_W-1:0] HLast    = COL_W'(HTotal - 1);
   localparam logic [COL_W-1:0] HSyncEnd = COL_W'(H_SYNC);
   localparam logic [COL_W-1:0] HActLo   = COL_W'(H_SYNC + H_BP);
   localparam logic [COL_W-1:0] HActHi   = COL_W'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [ROW_W-1:0] VLast    = ROW_W'(VTotal - 1);
   localparam logic [ROW_W-1:0] VSyncEnd = ROW_W'(V_SYNC);
   localparam logic [ROW_W-1:0] VActLo   = ROW_W'(V_SYNC + V_BP);
   localparam logic [ROW_W-1:0] VActHi   = ROW_W'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic             HdOn     = (HS_ACT_LOW != 0) ? 1'b0 : 1'b1;
   localparam logic             VdOn     = (VS_ACT_LOW != 0) ? 1'b0 : 1'b1;

   // Counters
   logic [DivW-1:0]  d_q, d_d;
   logic [COL_W-1:0] h_q, h_d;
   logic [ROW_W-1:0] v_q, v_d;
   // Frames completed by the counters; the visible FRAME_CNT trails this by
   // one clock so it changes together with FRAME_START.
   logic [15:0]      fcnt_q, fcnt_d;

   // Output registers
   logic             grest_q;
   logic             hd_q, hd_d;
   logic             vd_q, vd_d;
   logic             den_q, den_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             pix_q, pix_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;
   logic [15:0]      frame_q;

   logic tick;
   logic h_act, v_act;

   assign tick = (d_q == DLast);

   always_comb begin
      d_d    = d_q + DivW'(1);
      h_d    = h_q;
      v_d    = v_q;
      fcnt_d = fcnt_q;
      if (tick) begin
         d_d = '0;
         if (h_q == HLast) begin
            h_d = '0;
            if (v_q == VLast) begin
               v_d    = '0;
               fcnt_d = fcnt_q + 16'd1;
            end else begin
               v_d = v_q + ROW_W'(1);
            end
         end else begin
            h_d = h_q + COL_W'(1);
         end
      end
   end

   always_comb begin
      h_act = (h_q >= HActLo) && (h_q <= HActHi);
      v_act = (v_q >= VActLo) && (v_q <= VActHi);
      hd_d  = (h_q < HSyncEnd) ? HdOn : ~HdOn;
      vd_d  = (v_q < VSyncEnd) ? VdOn : ~VdOn;
      den_d = h_act && v_act;
      col_d = '0;
      row_d = '0;
      if (den_d) begin
         col_d = h_q - HActLo;
         row_d = v_q - VActLo;
      end
      // d == 0 marks the first clock of a pixel period.
      pix_d = (d_q == '0);
      ls_d  = pix_d && (h_q == '0);
      fs_d  = ls_d && (v_q == '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         d_q     <= '0;
         h_q     <= '0;
         v_q     <= '0;
         fcnt_q  <= '0;
         grest_q <= 1'b0;
         hd_q    <= ~HdOn;
         vd_q    <= ~VdOn;
         den_q   <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         pix_q   <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         frame_q <= '0;
      end else begin
         d_q     <= d_d;
         h_q     <= h_d;
         v_q     <= v_d;
         fcnt_q  <= fcnt_d;
         grest_q <= 1'b1;
         hd_q    <= hd_d;
         vd_q    <= vd_d;
         den_q   <= den_d;
         col_q   <= col_d;
         row_q   <= row_d;
         pix_q   <= pix_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
         frame_q <= fcnt_q;
      end
   end

   assign lcd.GREST       = grest_q;
   assign lcd.HD          = hd_q;
   assign lcd.VD          = vd_q;
   assign lcd.DEN         = den_q;
   assign lcd.Columna     = col_q;
   assign lcd.Fila        = row_q;
   assign lcd.PIX_TICK    = pix_q;
   assign lcd.LINE_START  = ls_q;
   assign lcd.FRAME_START = fs_q;
   assign lcd.FRAME_CNT   = frame_q;

endmodule

// File: tb/tb_lcd_sync_gen.sv
// Bench for lcd_sync_gen: three instances (defaults; CLK_DIV=2 with
// active-high HD; a tiny 7x6 geometry) checked every cycle against an
// arithmetic model, plus hand-computed literal expectations.
module tb_lcd_sync_gen;

   typedef struct packed {
      logic        grest;
      logic        hd;
      logic        vd;
      logic        den;
      logic [10:0] col;
      logic [9:0]  row;
      logic        pix;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   logic clk;
   logic rst;
   int   k;        // edges since reset release minus one; -1 while in reset
   bit   started;
   int   n_tests;
   int   n_fail;

   lcd_sync_gen_if #(.COL_W(11), .ROW_W(10)) if_a ();
   lcd_sync_gen_if #(.COL_W(11), .ROW_W(10)) if_b ();
   lcd_sync_gen_if #(.COL_W(11), .ROW_W(10)) if_c ();

   lcd_sync_gen u_a (
      .CLK (clk),
      .RST (rst),
      .lcd (if_a)
   );

   lcd_sync_gen #(
      .CLK_DIV    (2),
      .HS_ACT_LOW (0)
   ) u_b (
      .CLK (clk),
      .RST (rst),
      .lcd (if_b)
   );

   lcd_sync_gen #(
      .H_ACTIVE (4),
      .H_FP     (1),
      .H_SYNC   (1),
      .H_BP     (1),
      .V_ACTIVE (3),
      .V_FP     (1),
      .V_SYNC   (1),
      .V_BP     (1)
   ) u_c (
      .CLK (clk),
      .RST (rst),
      .lcd (if_c)
   );

   exp_t got_a, got_b, got_c;
   assign got_a = {if_a.GREST, if_a.HD, if_a.VD, if_a.DEN, if_a.Columna, if_a.Fila,
                   if_a.PIX_TICK, if_a.LINE_START, if_a.FRAME_START, if_a.FRAME_CNT};
   assign got_b = {if_b.GREST, if_b.HD, if_b.VD, if_b.DEN, if_b.Columna, if_b.Fila,
                   if_b.PIX_TICK, if_b.LINE_START, if_b.FRAME_START, if_b.FRAME_CNT};
   assign got_c = {if_c.GREST, if_c.HD, if_c.VD, if_c.DEN, if_c.Columna, if_c.Fila,
                   if_c.PIX_TICK, if_c.LINE_START, if_c.FRAME_START, if_c.FRAME_CNT};

   // Expected outputs k clocks after the first post-reset edge, from the
   // pixel index p = k / div and its position in the line/frame.
   function automatic exp_t model(input int kk, input int ha, input int hfp, input int hs,
                                  input int hbp, input int va, input int vfp, input int vs,
                                  input int vbp, input int div, input int hlow,
                                  input int vlow);
      exp_t e;
      int   p, ph, ht, vt, h, v, f;
      bit   hact, vact;
      e = '0;
      if (kk < 0) begin
         e.hd = (hlow != 0);
         e.vd = (vlow != 0);
         return e;
      end
      ht    = hs + hbp + ha + hfp;
      vt    = vs + vbp + va + vfp;
      p     = kk / div;
      ph    = kk % div;
      h     = p % ht;
      v     = (p / ht) % vt;
      f     = p / (ht * vt);
      hact  = (h >= hs + hbp) && (h < hs + hbp + ha);
      vact  = (v >= vs + vbp) && (v < vs + vbp + va);
      e.grest = 1'b1;
      e.hd    = (h < hs) ? (hlow == 0) : (hlow != 0);
      e.vd    = (v < vs) ? (vlow == 0) : (vlow != 0);
      e.den   = hact && vact;
      if (e.den) begin
         e.col = 11'(h - hs - hbp);
         e.row = 10'(v - vs - vbp);
      end
      e.pix = (ph == 0);
      e.ls  = (ph == 0) && (h == 0);
      e.fs  = (ph == 0) && (h == 0) && (v == 0);
      e.fc  = 16'(f);
      return e;
   endfunction

   task automatic chk(input string name, input longint got, input longint exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (k=%0d)", name, got, exp, k);
      end
   endtask

   task automatic cmp(input string name, input exp_t got, input exp_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s k=%0d: got g%0b h%0b v%0b d%0b c%0d r%0d p%0b l%0b f%0b n%0d, expected g%0b h%0b v%0b d%0b c%0d r%0d p%0b l%0b f%0b n%0d",
                  name, k, got.grest, got.hd, got.vd, got.den, got.col, got.row, got.pix,
                  got.ls, got.fs, got.fc, exp.grest, exp.hd, exp.vd, exp.den, exp.col,
                  exp.row, exp.pix, exp.ls, exp.fs, exp.fc);
      end
   endtask

   always @(posedge clk) begin
      started <= 1'b1;
      k       <= rst ? -1 : k + 1;
   end

   always @(negedge clk) begin
      if (started) begin
         cmp("cyc_a", got_a, model(k, 800, 210, 1, 45, 480, 22, 1, 22, 1, 1, 1));
         cmp("cyc_b", got_b, model(k, 800, 210, 1, 45, 480, 22, 1, 22, 2, 0, 1));
         cmp("cyc_c", got_c, model(k, 4, 1, 1, 1, 3, 1, 1, 1, 1, 1, 1));
      end
   end

   int a_hd_low, a_den_first, a_col0, a_row0, a_den_run, a_col_last;
   int b_hd_hi, b_pix, b_rise2;
   bit b_hd_prev;
   int c_fs_n;
   int c_fs_e [3];
   int c_fc   [3];
   int e;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b1;
      @(negedge clk);
      chk("rst_grest", if_a.GREST, 0);
      chk("rst_hd", if_a.HD, 1);
      chk("rst_vd", if_a.VD, 1);
      chk("rst_den", if_a.DEN, 0);
      @(negedge clk);
      rst = 1'b0;

      while (k < 50078) begin
         @(negedge clk);
         e = k + 1;
         if (e == 1) begin
            chk("e1_grest", if_a.GREST, 1);
            chk("e1_hd", if_a.HD, 0);
            chk("e1_vd", if_a.VD, 0);
            chk("e1_fs", if_a.FRAME_START, 1);
            chk("e1_ls", if_a.LINE_START, 1);
            chk("e1_pix", if_a.PIX_TICK, 1);
            chk("e1_b_hd", if_b.HD, 1);
         end
         if (e == 2) begin
            chk("e2_a_pix", if_a.PIX_TICK, 1);
            chk("e2_b_pix", if_b.PIX_TICK, 0);
            chk("e2_b_ls", if_b.LINE_START, 0);
            chk("e2_b_hd", if_b.HD, 1);
         end
         if (e <= 1056 && !if_a.HD) a_hd_low++;
         if (a_den_first == 0 && if_a.DEN) begin
            a_den_first = e;
            a_col0      = int'(if_a.Columna);
            a_row0      = int'(if_a.Fila);
         end
         if (a_den_first != 0 && e < a_den_first + 1056 && if_a.DEN) begin
            a_den_run++;
            a_col_last = int'(if_a.Columna);
         end
         if (e <= 2112) begin
            b_hd_hi += int'(if_b.HD);
            b_pix   += int'(if_b.PIX_TICK);
         end
         if (e > 2 && if_b.HD && !b_hd_prev && b_rise2 == 0) b_rise2 = e;
         b_hd_prev = if_b.HD;
         if (e == 48669) begin
            chk("b_den_first", if_b.DEN, 1);
            chk("b_col_e48669", if_b.Columna, 0);
            chk("b_row_e48669", if_b.Fila, 0);
         end
         if (e == 48670) chk("b_col_hold", if_b.Columna, 0);
         if (e == 48671) chk("b_col_next", if_b.Columna, 1);
         if (if_c.FRAME_START && c_fs_n < 3) begin
            c_fs_e[c_fs_n] = e;
            c_fc[c_fs_n]   = int'(if_c.FRAME_CNT);
            c_fs_n++;
         end
         if (e == 8) chk("c_ls_e8", if_c.LINE_START, 1);
         if (e == 17) begin
            chk("c_den_e17", if_c.DEN, 1);
            chk("c_col_e17", if_c.Columna, 0);
            chk("c_row_e17", if_c.Fila, 0);
         end
         if (e == 20) chk("c_col_e20", if_c.Columna, 3);
         if (e == 21) chk("c_den_e21", if_c.DEN, 0);
      end

      chk("a_hd_low_per_line", a_hd_low, 1);
      chk("a_den_first_edge", a_den_first, 24335);
      chk("a_den_first_col", a_col0, 0);
      chk("a_den_first_row", a_row0, 0);
      chk("a_den_run", a_den_run, 800);
      chk("a_col_last", a_col_last, 799);
      chk("b_hd_high_cycles", b_hd_hi, 2);
      chk("b_pix_ticks", b_pix, 1056);
      chk("b_hd_period", b_rise2, 2113);
      chk("c_fs_count", c_fs_n, 3);
      chk("c_fs0_edge", c_fs_e[0], 1);
      chk("c_fs1_edge", c_fs_e[1], 43);
      chk("c_fs2_edge", c_fs_e[2], 85);
      chk("c_fc0", c_fc[0], 0);
      chk("c_fc1", c_fc[1], 1);
      chk("c_fc2", c_fc[2], 2);

      // Mid-line reset on line 24 of the active area, at column 400.
      chk("mid_a_col", if_a.Columna, 400);
      chk("mid_a_row", if_a.Fila, 24);
      chk("mid_a_den", if_a.DEN, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_grest", if_a.GREST, 0);
      chk("mid_rst_hd", if_a.HD, 1);
      chk("mid_rst_vd", if_a.VD, 1);
      chk("mid_rst_den", if_a.DEN, 0);
      chk("mid_rst_col", if_a.Columna, 0);
      chk("mid_rst_row", if_a.Fila, 0);
      chk("mid_rst_pix", if_a.PIX_TICK, 0);
      chk("mid_rst_fs", if_a.FRAME_START, 0);
      chk("mid_rst_c_fc", if_c.FRAME_CNT, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("restart_grest", if_a.GREST, 1);
      chk("restart_fs", if_a.FRAME_START, 1);
      chk("restart_fc", if_a.FRAME_CNT, 0);
      repeat (100) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
